serial_to_parallel_receiver_8_bit: RTL and testbench

Serial-in, parallel-out receiver that reassembles bytes from a strobed one-bit stream produced by an 8-bit universal shift register running in a shift mode. Supports both bit orders: LSB-first for a shift-right transmitter, and MSB-first for a shift-left transmitter. Each completed byte is presented on a one-entry valid/ready output buffer, with sticky overrun detection. The block sits at the receiving end of the serial link, feeding byte-wide consumers.

---
 rtl/serial_to_parallel_receiver_8_bit.sv | 157 +++++++++++++++
 tb/tb_serial_to_parallel_receiver_8_bit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_receiver_8_bit.sv
`default_nettype none
// ============================================================================
// Module   : serial_to_parallel_receiver_8_bit
// Brief    : Reassembles bytes from a strobed serial stream, LSB- or MSB-first,
//            into a one-entry valid/ready buffer with sticky overrun.
//            Optional parity bit per byte when PARITY_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module serial_to_parallel_receiver_8_bit #(
    parameter int PARITY_ODD = 0
) (
    input  logic       Clk_In,
    input  logic       Reset_In,
    input  logic       Serial_Data_In,
    input  logic       Serial_Valid_In,
    input  logic       Frame_Start_In,
    input  logic       Bit_Order_In,
    output logic [7:0] Byte_Data_Out,
    output logic       Byte_Valid_Out,
    input  logic       Byte_Ready_In,
    output logic       Parity_Error_Out,
    output logic       Overrun_Out,
    output logic [3:0] Bit_Count_Out
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DATA   = 2'd1;
`ifdef PARITY_CHECK_EN
    localparam logic [1:0] c_ST_PARITY = 2'd2;
`endif
    localparam logic       c_parity_odd = (PARITY_ODD != 0);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic [3:0] r_count;
    logic [3:0] w_count_nxt;
    logic       r_order;
    logic       w_order_nxt;
    logic [7:0] w_shifted;

    logic       w_complete;
    logic [7:0] w_byte;
    logic       w_perr;

    logic       r_valid;
    logic [7:0] r_data;
    logic       r_perr;
    logic       r_overrun;
    logic       w_accept;
    logic       w_load;
    logic       w_drop;

    // MSB-first shifts left (new bit at [0]); LSB-first shifts right (new bit at [7])
    assign w_shifted = r_order ? {r_shift[6:0], Serial_Data_In}
                               : {Serial_Data_In, r_shift[7:1]};

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            r_state <= c_ST_IDLE;
            r_shift <= 8'd0;
            r_count <= 4'd0;
            r_order <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_count <= w_count_nxt;
            r_order <= w_order_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_count_nxt = r_count;
        w_order_nxt = r_order;
        w_complete  = 1'b0;
        w_byte      = w_shifted;
        w_perr      = 1'b0;
        if (Serial_Valid_In) begin
            if (Frame_Start_In) begin
                // A frame start always wins: any partial byte is silently dropped
                w_order_nxt = Bit_Order_In;
                w_shift_nxt = Bit_Order_In ? {7'd0, Serial_Data_In}
                                           : {Serial_Data_In, 7'd0};
                w_count_nxt = 4'd1;
                w_state_nxt = c_ST_DATA;
            end else begin
                case (r_state)
                    c_ST_DATA: begin
                        w_shift_nxt = w_shifted;
                        if (r_count == 4'd7) begin
`ifdef PARITY_CHECK_EN
                            w_count_nxt = 4'd8;
                            w_state_nxt = c_ST_PARITY;
`else
                            w_count_nxt = 4'd0;
                            w_complete  = 1'b1;
                            // Parity sense is irrelevant without a parity bit; term folds to 0
                            w_perr      = c_parity_odd & 1'b0;
`endif
                        end else begin
                            w_count_nxt = r_count + 4'd1;
                        end
                    end
`ifdef PARITY_CHECK_EN
                    c_ST_PARITY: begin
                        w_complete  = 1'b1;
                        w_byte      = r_shift;
                        w_perr      = ((^r_shift) ^ Serial_Data_In) != c_parity_odd;
                        w_count_nxt = 4'd0;
                        w_state_nxt = c_ST_DATA;
                    end
`endif
                    default: begin
                        w_state_nxt = r_state;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_accept = r_valid & Byte_Ready_In;
        w_load   = w_complete & (~r_valid | w_accept);
        w_drop   = w_complete & r_valid & ~w_accept;
    end

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            r_valid   <= 1'b0;
            r_data    <= 8'd0;
            r_perr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= w_byte;
                r_perr  <= w_perr;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign Byte_Data_Out    = r_data;
    assign Byte_Valid_Out   = r_valid;
    assign Parity_Error_Out = r_perr;
    assign Overrun_Out      = r_overrun;
    assign Bit_Count_Out    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_serial_to_parallel_receiver_8_bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_to_parallel_receiver_8_bit
// Brief    : Scoreboard bench for serial_to_parallel_receiver_8_bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_to_parallel_receiver_8_bit;

    logic       Clk_In          = 1'b0;
    logic       Reset_In        = 1'b1;
    logic       Serial_Data_In  = 1'b0;
    logic       Serial_Valid_In = 1'b0;
    logic       Frame_Start_In  = 1'b0;
    logic       Bit_Order_In    = 1'b0;
    logic       Byte_Ready_In   = 1'b0;
    logic [7:0] Byte_Data_Out;
    logic       Byte_Valid_Out;
    logic       Parity_Error_Out;
    logic       Overrun_Out;
    logic [3:0] Bit_Count_Out;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_item;

`ifdef PARITY_CHECK_EN
    localparam logic [3:0] c_CNT_LAST = 4'd8;
`else
    localparam logic [3:0] c_CNT_LAST = 4'd0;
`endif

    always #5 Clk_In = ~Clk_In;

    serial_to_parallel_receiver_8_bit #(.PARITY_ODD(0)) u_dut (
        .Clk_In           (Clk_In),
        .Reset_In         (Reset_In),
        .Serial_Data_In   (Serial_Data_In),
        .Serial_Valid_In  (Serial_Valid_In),
        .Frame_Start_In   (Frame_Start_In),
        .Bit_Order_In     (Bit_Order_In),
        .Byte_Data_Out    (Byte_Data_Out),
        .Byte_Valid_Out   (Byte_Valid_Out),
        .Byte_Ready_In    (Byte_Ready_In),
        .Parity_Error_Out (Parity_Error_Out),
        .Overrun_Out      (Overrun_Out),
        .Bit_Count_Out    (Bit_Count_Out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted byte must match the head of the scoreboard
    always @(negedge Clk_In) begin
        if (!Reset_In && Byte_Valid_Out && Byte_Ready_In) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_byte: got 0x%0h expected none", Byte_Data_Out);
            end else begin
                exp_item = exp_q.pop_front();
                check("byte", {23'd0, Parity_Error_Out, Byte_Data_Out}, {23'd0, exp_item});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk_In);
            #2;
        end
    endtask

    task automatic send_bit(input logic b, input logic fs, input logic ord);
        Serial_Data_In  = b;
        Serial_Valid_In = 1'b1;
        Frame_Start_In  = fs;
        Bit_Order_In    = ord;
        @(posedge Clk_In);
        #2;
        Serial_Valid_In = 1'b0;
        Frame_Start_In  = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] d, input logic ord, input logic fs);
        for (int i = 0; i < 8; i++)
            send_bit(ord ? d[7-i] : d[i], fs && (i == 0), ord);
    endtask

    // Full byte; with parity compiled in, appends an even-parity-correct bit
    task automatic send_byte(input logic [7:0] d, input logic ord, input logic fs);
        send_data(d, ord, fs);
`ifdef PARITY_CHECK_EN
        send_bit(^d, 1'b0, ord);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  {24'd0, Byte_Data_Out}, 32'h00);
        check({tag, "_valid"}, {31'd0, Byte_Valid_Out}, 32'd0);
        check({tag, "_perr"},  {31'd0, Parity_Error_Out}, 32'd0);
        check({tag, "_ovr"},   {31'd0, Overrun_Out}, 32'd0);
        check({tag, "_cnt"},   {28'd0, Bit_Count_Out}, 32'd0);
    endtask

    task automatic do_reset();
        Reset_In = 1'b1;
        @(posedge Clk_In);
        #2;
        Reset_In = 1'b0;
        check_all_zero("reset");
    endtask

    initial begin
        do_reset();

        // LSB first 0xA5, latency and drain
        Byte_Ready_In = 1'b1;
        exp_q.push_back({1'b0, 8'hA5});
        send_byte(8'hA5, 1'b0, 1'b1);
        check("a5_valid", {31'd0, Byte_Valid_Out}, 32'd1);
        check("a5_data", {24'd0, Byte_Data_Out}, 32'hA5);
        idle(1);
        check("a5_drain", {31'd0, Byte_Valid_Out}, 32'd0);

        // MSB first 0x3C with strobe gaps; count steps and holds across gaps
        exp_q.push_back({1'b0, 8'h3C});
        for (int i = 0; i < 8; i++) begin
            automatic logic [7:0] pat = 8'h3C;
            send_bit(pat[7-i], i == 0, 1'b1);
            check("cnt_step", {28'd0, Bit_Count_Out}, (i == 7) ? {28'd0, c_CNT_LAST} : i + 1);
            idle($urandom_range(1, 3));
            check("cnt_hold", {28'd0, Bit_Count_Out}, (i == 7) ? {28'd0, c_CNT_LAST} : i + 1);
        end
`ifdef PARITY_CHECK_EN
        send_bit(1'b0, 1'b0, 1'b1);
`endif
        idle(2);

        // Overrun: ready low across two bytes
        do_reset();
        Byte_Ready_In = 1'b0;
        exp_q.push_back({1'b0, 8'h11});
        send_byte(8'h11, 1'b0, 1'b1);
        send_byte(8'h22, 1'b0, 1'b0);
        check("ovr_set", {31'd0, Overrun_Out}, 32'd1);
        check("ovr_keep", {24'd0, Byte_Data_Out}, 32'h11);
        check("ovr_valid", {31'd0, Byte_Valid_Out}, 32'd1);
        Byte_Ready_In = 1'b1;
        idle(1);
        check("ovr_drain", {31'd0, Byte_Valid_Out}, 32'd0);
        check("ovr_sticky", {31'd0, Overrun_Out}, 32'd1);

        // Frame restart after 5 bits
        do_reset();
        exp_q.push_back({1'b0, 8'hF0});
        for (int i = 0; i < 5; i++)
            send_bit(1'b1, i == 0, 1'b0);
        check("restart_cnt5", {28'd0, Bit_Count_Out}, 32'd5);
        send_byte(8'hF0, 1'b0, 1'b1);
        idle(2);
        check("restart_ovr", {31'd0, Overrun_Out}, 32'd0);
        check("restart_q", exp_q.size(), 32'd0);

        // Back-to-back bytes with ready held high
        do_reset();
        exp_q.push_back({1'b0, 8'h5A});
        exp_q.push_back({1'b0, 8'hC3});
        send_byte(8'h5A, 1'b0, 1'b1);
        send_byte(8'hC3, 1'b0, 1'b0);
        idle(2);
        check("b2b_ovr", {31'd0, Overrun_Out}, 32'd0);
        check("b2b_valid", {31'd0, Byte_Valid_Out}, 32'd0);

`ifdef PARITY_CHECK_EN
        // Even parity: 0x07 has three ones
        do_reset();
        exp_q.push_back({1'b0, 8'h07});
        send_data(8'h07, 1'b0, 1'b1);
        check("par_cnt8", {28'd0, Bit_Count_Out}, 32'd8);
        send_bit(1'b1, 1'b0, 1'b0);
        exp_q.push_back({1'b1, 8'h07});
        send_data(8'h07, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        idle(2);
`endif

        // Reset mid-frame, then bits without frame start are ignored
        do_reset();
        for (int i = 0; i < 4; i++)
            send_bit(1'b1, i == 0, 1'b0);
        Reset_In = 1'b1;
        idle(1);
        Reset_In = 1'b0;
        send_data(8'hFF, 1'b0, 1'b0);
        idle(2);
        check_all_zero("midrst");

        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
